// File: rtl/delay_irq_core.sv
// Cycle-counting timing engine with one-shot/periodic expiry, optional trigger arming,
// a level interrupt with sticky overrun, and a saturating expiry-event counter.
module delay_irq_core #(
  parameter int CNT_WIDTH = 32,
  parameter int EVT_WIDTH = 16
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic [CNT_WIDTH-1:0] cfg_delay,
  input  logic                 cfg_enable,
  input  logic                 cfg_periodic,
  input  logic                 cfg_trig_sel,
  input  logic                 start,
  input  logic                 trig_in,
  input  logic                 irq_ack,
  output logic                 irq,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] count_val,
  output logic [EVT_WIDTH-1:0] evt_cnt,
  output logic                 overrun
);

  typedef enum logic [1:0] {IDLE, ARMED, COUNT} state_t;

  state_t state;
  logic   periodic_q;
  logic   expiry;

  // An abort (enable low) on the same edge suppresses the expiry entirely.
  assign expiry = (state == COUNT) && cfg_enable && (count_val == '0);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state      <= IDLE;
      periodic_q <= 1'b0;
      irq        <= 1'b0;
      busy       <= 1'b0;
      count_val  <= '0;
      evt_cnt    <= '0;
      overrun    <= 1'b0;
    end else begin
      // Expiry beats a coincident acknowledge for irq; ack always clears overrun.
      if (expiry) begin
        irq <= 1'b1;
        if (evt_cnt != '1)
          evt_cnt <= evt_cnt + EVT_WIDTH'(1);
      end else if (irq_ack) begin
        irq <= 1'b0;
      end

      if (irq_ack)
        overrun <= 1'b0;
      else if (expiry && irq)
        overrun <= 1'b1;

      if (state != IDLE && !cfg_enable) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && cfg_enable) begin
              busy <= 1'b1;
              if (cfg_trig_sel) begin
                state <= ARMED;
              end else begin
                state      <= COUNT;
                count_val  <= cfg_delay;
                periodic_q <= cfg_periodic;
              end
            end
          end
          ARMED: begin
            if (trig_in) begin
              state      <= COUNT;
              count_val  <= cfg_delay;
              periodic_q <= cfg_periodic;
            end
          end
          COUNT: begin
            if (count_val != '0) begin
              count_val <= count_val - CNT_WIDTH'(1);
            end else if (periodic_q) begin
              // Reload picks up any configuration written during the last period.
              count_val  <= cfg_delay;
              periodic_q <= cfg_periodic;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_delay_irq_core.sv
// Randomized scoreboard bench for delay_irq_core: a deadline-based reference model
// predicts every cycle's outputs, a monitor process pops and compares them.
module tb_delay_irq_core;

  localparam int CW = 32;
  localparam int EW = 4;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic [CW-1:0] cfg_delay = '0;
  logic          cfg_enable = 1'b0;
  logic          cfg_periodic = 1'b0;
  logic          cfg_trig_sel = 1'b0;
  logic          start = 1'b0;
  logic          trig_in = 1'b0;
  logic          irq_ack = 1'b0;
  logic          irq;
  logic          busy;
  logic [CW-1:0] count_val;
  logic [EW-1:0] evt_cnt;
  logic          overrun;

  delay_irq_core #(.CNT_WIDTH(CW), .EVT_WIDTH(EW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .cfg_delay(cfg_delay), .cfg_enable(cfg_enable),
    .cfg_periodic(cfg_periodic), .cfg_trig_sel(cfg_trig_sel), .start(start),
    .trig_in(trig_in), .irq_ack(irq_ack), .irq(irq), .busy(busy),
    .count_val(count_val), .evt_cnt(evt_cnt), .overrun(overrun)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic          irq;
    logic          busy;
    logic          ovr;
    logic [CW-1:0] cnt;
    logic [EW-1:0] evt;
    longint        edge_no;
  } exp_t;

  exp_t   sb[$];
  int     testsRun = 0;
  int     testsFailed = 0;

  // Reference model: timeline of deadlines rather than a down-counter.
  longint cyc = 0;
  int     phase = 0;
  longint expireAt = 0;
  logic   periodicLatched = 1'b0;
  logic [CW-1:0] frozenCnt = '0;
  logic   mIrq = 1'b0;
  logic   mOvr = 1'b0;
  int     mEvt = 0;

  task automatic checkOutput(input string name, input longint got, input longint want, input longint e);
    testsRun++;
    if (got != want) begin
      testsFailed++;
      $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", name, e, got, want);
    end
  endtask

  task automatic loadTimer(input logic [CW-1:0] d, input logic p);
    phase           = 2;
    expireAt        = cyc + longint'(d) + 1;
    periodicLatched = p;
  endtask

  task automatic pushExpected();
    exp_t x;
    x.irq     = mIrq;
    x.busy    = (phase != 0);
    x.ovr     = mOvr;
    x.cnt     = (phase == 2) ? CW'(expireAt - 1 - cyc) : frozenCnt;
    x.evt     = EW'(mEvt);
    x.edge_no = cyc;
    sb.push_back(x);
  endtask

  task automatic modelStep();
    logic hit;
    hit = (phase == 2) && cfg_enable && (cyc == expireAt);
    mOvr = irq_ack ? 1'b0 : ((hit && mIrq) ? 1'b1 : mOvr);
    mIrq = hit ? 1'b1 : (irq_ack ? 1'b0 : mIrq);
    if (hit && mEvt < (1 << EW) - 1) mEvt++;
    if (phase != 0 && !cfg_enable) begin
      if (phase == 2) frozenCnt = CW'(expireAt - cyc);
      phase = 0;
    end else if (phase == 0) begin
      if (start && cfg_enable) begin
        if (cfg_trig_sel) phase = 1;
        else loadTimer(cfg_delay, cfg_periodic);
      end
    end else if (phase == 1) begin
      if (trig_in) loadTimer(cfg_delay, cfg_periodic);
    end else if (hit) begin
      if (periodicLatched) loadTimer(cfg_delay, cfg_periodic);
      else begin
        phase     = 0;
        frozenCnt = '0;
      end
    end
  endtask

  task automatic applyStimulus(input logic s, input logic t, input logic a, input logic e,
                               input logic [CW-1:0] d, input logic p, input logic ts);
    @(negedge ACLK);
    start = s; trig_in = t; irq_ack = a; cfg_enable = e;
    cfg_delay = d; cfg_periodic = p; cfg_trig_sel = ts;
    cyc++;
    modelStep();
    pushExpected();
  endtask

  // Asserts reset away from the clock edge and checks the outputs clear immediately.
  task automatic doReset();
    @(negedge ACLK);
    ARESETN = 1'b0;
    start = 1'b0; trig_in = 1'b0; irq_ack = 1'b0;
    #1;
    checkOutput("reset_irq", irq, 0, cyc);
    checkOutput("reset_busy", busy, 0, cyc);
    checkOutput("reset_count", count_val, 0, cyc);
    checkOutput("reset_evt", evt_cnt, 0, cyc);
    checkOutput("reset_overrun", overrun, 0, cyc);
    phase = 0; frozenCnt = '0; mIrq = 1'b0; mOvr = 1'b0; mEvt = 0;
    cyc++;
    pushExpected();
    @(posedge ACLK);
    #2;
    ARESETN = 1'b1;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge ACLK);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        checkOutput("irq", irq, x.irq, x.edge_no);
        checkOutput("busy", busy, x.busy, x.edge_no);
        checkOutput("overrun", overrun, x.ovr, x.edge_no);
        checkOutput("count_val", count_val, x.cnt, x.edge_no);
        checkOutput("evt_cnt", evt_cnt, x.evt, x.edge_no);
      end
    end
  end

  initial begin : driver
    logic [CW-1:0] d;
    logic p, ts, e;
    doReset();
    // One-shot, delay 10, then acknowledge.
    applyStimulus(1, 0, 0, 1, 10, 0, 0);
    for (int i = 0; i < 13; i++) applyStimulus(0, 0, 0, 1, 10, 0, 0);
    applyStimulus(0, 0, 1, 1, 10, 0, 0);
    // Zero delay twice without ack produces overrun.
    applyStimulus(1, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0, 0);
    // Periodic with a delay change mid-period.
    applyStimulus(1, 0, 0, 1, 4, 1, 0);
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, irq, 1, 4, 1, 0);
    for (int i = 0; i < 30; i++) applyStimulus(0, 0, irq, 1, 9, 1, 0);
    applyStimulus(0, 0, 1, 0, 9, 0, 0);
    applyStimulus(0, 0, 1, 1, 9, 0, 0);
    // Trigger mode: armed wait, trigger, then a stray trigger while counting.
    applyStimulus(1, 0, 0, 1, 3, 0, 1);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 1, 3, 0, 1);
    applyStimulus(0, 1, 0, 1, 3, 0, 1);
    applyStimulus(0, 0, 0, 1, 3, 0, 1);
    applyStimulus(0, 1, 0, 1, 3, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 3, 0, 1);
    applyStimulus(0, 0, 1, 1, 3, 0, 1);
    // Abort mid-count, restart, then asynchronous reset mid-count.
    applyStimulus(1, 0, 0, 1, 20, 0, 0);
    for (int i = 0; i < 15; i++) applyStimulus(0, 0, 0, 1, 20, 0, 0);
    applyStimulus(0, 0, 0, 0, 20, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 20, 0, 0);
    applyStimulus(1, 0, 0, 1, 8, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 8, 0, 0);
    doReset();
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 1, 8, 0, 0);
    // Saturation with back-to-back expiries, then ack coincident with expiry.
    applyStimulus(1, 0, 0, 1, 0, 1, 0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 1, 0, 1, 0);
    applyStimulus(0, 0, 1, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0, 0);
    // Randomized traffic.
    d = 5; p = 0; ts = 0; e = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) doReset();
      if ($urandom_range(0, 15) == 0) d = CW'($urandom_range(0, 12));
      if ($urandom_range(0, 15) == 0) p = ~p;
      if ($urandom_range(0, 15) == 0) ts = ~ts;
      if (e) e = ($urandom_range(0, 49) != 0);
      else   e = ($urandom_range(0, 3) == 0);
      applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 4) == 0, e, d, p, ts);
    end
    @(posedge ACLK);
    #3;
    checkOutput("scoreboard_drain", sb.size(), 0, cyc);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
